// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver with majority-voted bits and a first-word-fall-through FIFO
module uart_rx_fifo #(
    parameter int SERIAL_WCNT = 120,
    parameter int FIFO_LOG    = 2
) (
    input  logic       CLK,
    input  logic       RST_X,
    input  logic       RXD,
    input  logic       RE,
    input  logic       CLR_ERR,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FERR,
    output logic       OVERRUN
);

    localparam int HALF  = SERIAL_WCNT / 2;
    localparam int CW    = $clog2(SERIAL_WCNT);
    localparam int DEPTH = 1 << FIFO_LOG;

    localparam logic [CW-1:0]     C_LAST = CW'(SERIAL_WCNT - 1);
    localparam logic [CW-1:0]     C_HM1  = CW'(HALF - 1);
    localparam logic [CW-1:0]     C_HALF = CW'(HALF);
    localparam logic [CW-1:0]     C_DEC  = CW'(HALF + 1);
    localparam logic [FIFO_LOG:0] C_FULL = (FIFO_LOG + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic          sync1, rxs;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bidx, bidx_n;
    logic [7:0]    shreg, shreg_n;
    logic          samp_a, samp_b;
    logic          maj, decide, wrap;
    logic          push, ferr_set;

    logic [7:0]          mem [DEPTH];
    logic [FIFO_LOG-1:0] wptr, rptr;
    logic [FIFO_LOG:0]   count;
    logic                pop, full, wr, ovr_set;

    // The third vote is the live sample, so the decision lands on cnt == HALF+1.
    assign maj    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign decide = (cnt == C_DEC);
    assign wrap   = (cnt == C_LAST);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync1  <= 1'b1;
            rxs    <= 1'b1;
            state  <= S_IDLE;
            cnt    <= '0;
            bidx   <= '0;
            shreg  <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            sync1  <= RXD;
            rxs    <= sync1;
            state  <= state_n;
            cnt    <= cnt_n;
            bidx   <= bidx_n;
            shreg  <= shreg_n;
            if (cnt == C_HM1) samp_a <= rxs;
            if (cnt == C_HALF) samp_b <= rxs;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = wrap ? '0 : cnt + CW'(1);
        bidx_n   = bidx;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_IDLE: begin
                // The detecting cycle itself is cnt 0 of the start window.
                cnt_n = '0;
                if (!rxs) begin
                    state_n = S_START;
                    cnt_n   = CW'(1);
                end
            end
            S_START: begin
                if (decide && maj) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (wrap) begin
                    state_n = S_DATA;
                    bidx_n  = '0;
                end
            end
            S_DATA: begin
                if (decide) shreg_n = {maj, shreg[7:1]};
                if (wrap) begin
                    if (bidx == 3'd7) state_n = S_STOP;
                    else bidx_n = bidx + 3'd1;
                end
            end
            S_STOP: begin
                if (decide) begin
                    cnt_n = '0;
                    if (maj) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign VALID   = (count != '0);
    assign DATA    = mem[rptr];
    assign pop     = RE && VALID;
    assign full    = (count == C_FULL);
    assign wr      = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + FIFO_LOG'(1);
            end
            if (pop) rptr <= rptr + FIFO_LOG'(1);
            if (wr && !pop) count <= count + (FIFO_LOG + 1)'(1);
            else if (!wr && pop) count <= count - (FIFO_LOG + 1)'(1);
            FERR    <= ferr_set | (FERR & ~CLR_ERR);
            OVERRUN <= ovr_set | (OVERRUN & ~CLR_ERR);
        end
    end

endmodule
